// File: rtl/uart_rx_deserializer_if.sv
// Bundle of the serial-side inputs and parallel-side outputs of the UART
// receive deserializer. The slave modport is the deserializer itself; the
// master modport is whatever drives the line and the baud tick and consumes
// the received byte.
interface uart_rx_deserializer_if;
    logic       rx;             // serial line, idles high
    logic       tick16;         // single-cycle enable at OVERSAMPLE x baud
    logic [7:0] dout;           // last accepted data byte, bit0 = first received
    logic       rxp;            // raw parity bit of the last accepted frame
    logic       load;           // one-cycle strobe when dout/rxp update
    logic       framing_error;  // one-cycle strobe on a low stop bit
    logic       busy;           // high whenever a frame is in progress

    modport master (
        output rx,
        output tick16,
        input  dout,
        input  rxp,
        input  load,
        input  framing_error,
        input  busy
    );

    modport slave (
        input  rx,
        input  tick16,
        output dout,
        output rxp,
        output load,
        output framing_error,
        output busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronizes the serial line, finds the start
// edge, samples each bit at mid-bit using the oversampling tick, and presents
// the 8 data bits plus the raw parity bit with a one-cycle load strobe. Only
// framing (start and stop validity) is checked; parity is left to the checker
// downstream.
module uart_rx_deserializer #(
    parameter int OVERSAMPLE = 16   // ticks per bit; even and >= 4
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_rx_deserializer_if.slave bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    // Last tick index of half a bit (mid-start sample) and of a full bit.
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Line synchronizer and edge-detect history; all idle high.
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;
    logic rx_fall;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q,  tick_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q,   par_d;
    logic [7:0]    dout_q,  dout_d;
    logic          rxp_q,   rxp_d;
    logic          load_q,  load_d;
    logic          ferr_q,  ferr_d;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s_q;

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            rxp_q   <= 1'b0;
            load_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            rxp_q   <= rxp_d;
            load_q  <= load_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state and sampling decisions; only IDLE reacts without a tick.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        dout_d  = dout_q;
        rxp_d   = rxp_q;
        load_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a fresh falling edge arms a frame, so a held-low
                // break line never produces repeated frames.
                if (rx_fall) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end

            START: begin
                if (bus.tick16) begin
                    if (tick_q == HALF_LAST) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            // Line back high at mid-start: treat as noise.
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            DATA: begin
                if (bus.tick16) begin
                    if (tick_q == FULL_LAST) begin
                        shreg_d = {rx_s_q, shreg_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tick_d  = '0;
                        if (bit_q == 3'd7) begin
                            state_d = PARITY;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            PARITY: begin
                if (bus.tick16) begin
                    if (tick_q == FULL_LAST) begin
                        par_d   = rx_s_q;
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            STOP: begin
                if (bus.tick16) begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        state_d = IDLE;
                        if (rx_s_q) begin
                            dout_d = shreg_q;
                            rxp_d  = par_q;
                            load_d = 1'b1;
                        end else begin
                            // Bad stop bit: keep the previous byte visible.
                            ferr_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase
    end

    assign bus.dout          = dout_q;
    assign bus.rxp           = rxp_q;
    assign bus.load          = load_q;
    assign bus.framing_error = ferr_q;
    assign bus.busy          = (state_q != IDLE);

endmodule
